adder_arbiter: RTL and testbench

Shares one `WIDTH`-bit ripple `adder` among `NREQ` requesters. Each requester issues add or subtract operations over a valid/ready handshake. A round-robin arbiter grants at most one requester per cycle. The result goes into a single-entry output register with its own valid/ready handshake. The block sits between the ALU-side clients (PC/branch-target calculation, load/store address generation) and the shared adder instance.

---
 rtl/adder_arb_pkg.sv | 26 ++
 rtl/adder.sv | 37 +++
 rtl/rr_arbiter.sv | 63 ++++++
 rtl/adder_arbiter.sv | 129 ++++++++++++
 tb/tb_adder_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_arb_pkg.sv
// ============================================================================
//  Module      : adder_arb_pkg
//  Description : Shared types and limits for the adder_arbiter block.
//                adder_resp_t is the layout of the output register. Its
//                fields are sized for the largest supported configuration.
//                Users slice them down to WIDTH / IDW.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_arb_pkg;

   localparam int ADDER_ARB_MAX_NREQ  = 8;
   localparam int ADDER_ARB_MAX_WIDTH = 64;
   localparam int ADDER_ARB_MAX_IDW   = $clog2(ADDER_ARB_MAX_NREQ);

   typedef struct packed {
      logic [ADDER_ARB_MAX_WIDTH-1:0] sum;
      logic                           cout;
      logic                           ovf;
      logic [ADDER_ARB_MAX_IDW-1:0]   id;
   } adder_resp_t;

endpackage

`default_nettype wire

// File: rtl/adder.sv
// ============================================================================
//  Module      : adder
//  Description : WIDTH-bit ripple-carry adder.
//  Ports       : a, b  - operands
//                cin   - carry-in
//                sum   - a + b + cin (low WIDTH bits)
//                cout  - carry out of the MSB
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   // The carry ripples through a block-local variable.
   // This keeps the chain out of a self-referencing vector net.
   always_comb begin : p_ripple
      logic w_carry;
      w_carry = cin;
      sum     = '0;
      for (int i = 0; i < WIDTH; i++) begin
         sum[i]  = a[i] ^ b[i] ^ w_carry;
         w_carry = (a[i] & b[i]) | (w_carry & (a[i] ^ b[i]));
      end
      cout = w_carry;
   end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter.
//                The search starts at ptr, wraps modulo NREQ and picks the
//                first set request. ptr moves to winner+1 only when advance
//                is high, so idle requesters and stalled cycles never use up
//                a turn.
//  Ports       : clk, rst_n - clock, asynchronous active-low reset
//                req        - request vector
//                advance    - the current winner was accepted this cycle
//                grant      - one-hot winner (zero when no request)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
   import adder_arb_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic            advance,
   output logic [NREQ-1:0] grant
);

   localparam int IDW = $clog2(NREQ);

   logic [IDW-1:0] r_ptr;
   logic [IDW-1:0] w_win;
   logic           w_found;

   always_comb begin : p_search
      int v_idx;
      v_idx   = 0;
      w_found = 1'b0;
      w_win   = '0;
      grant   = '0;
      for (int k = 0; k < NREQ; k++) begin
         v_idx = int'(r_ptr) + k;
         if (v_idx >= NREQ) begin
            v_idx = v_idx - NREQ;
         end
         if (!w_found && req[v_idx]) begin
            w_found = 1'b1;
            w_win   = IDW'(v_idx);
         end
      end
      grant[w_win] = w_found;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (advance) begin
         r_ptr <= (w_win == IDW'(NREQ - 1)) ? '0 : w_win + IDW'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/adder_arbiter.sv
// ============================================================================
//  Module      : adder_arbiter
//  Description : Shares one ripple adder among NREQ add/subtract requesters.
//                A round-robin grant selects one requester per cycle. Its
//                result is captured in a single-entry output register with a
//                valid/ready handshake.
//  Ports       : clk, rst_n          - clock, asynchronous active-low reset
//                req_valid/req_ready - per-requester handshake
//                req_a, req_b        - operand slices, slice i = requester i
//                req_sub             - 1: A-B, 0: A+B
//                resp_valid/ready    - output handshake
//                resp_sum/cout/ovf   - result and flags
//                resp_id             - index of the producing requester
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_arbiter
   import adder_arb_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NREQ  = 4,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ-1:0]       req_sub,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [WIDTH-1:0]      resp_sum,
   output logic                  resp_cout,
   output logic                  resp_ovf,
   output logic [IDW-1:0]        resp_id
);

   logic [NREQ-1:0]  w_grant;
   logic             w_can_accept;
   logic             w_advance;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH-1:0] w_b_eff;
   logic [WIDTH-1:0] w_sum;
   logic             w_sub;
   logic             w_cout;
   logic             w_ovf;
   logic [IDW-1:0]   w_id;

   logic             r_valid;
   adder_resp_t      r_resp;

   rr_arbiter #(
      .NREQ    (NREQ)
   ) u_rr (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_valid),
      .advance (w_advance),
      .grant   (w_grant)
   );

   // A full register that is being drained can take a new result on the
   // same edge. ready is also forced low while reset is held.
   assign w_can_accept = !r_valid | resp_ready;
   assign req_ready    = w_grant & {NREQ{w_can_accept & rst_n}};
   assign w_advance    = |(req_valid & req_ready);

   // Operand mux, driven by the one-hot grant.
   always_comb begin
      w_a   = '0;
      w_b   = '0;
      w_sub = 1'b0;
      w_id  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_grant[i]) begin
            w_a   = req_a[i*WIDTH +: WIDTH];
            w_b   = req_b[i*WIDTH +: WIDTH];
            w_sub = req_sub[i];
            w_id  = IDW'(i);
         end
      end
   end

   // Subtract is A + ~B + 1.
   assign w_b_eff = w_b ^ {WIDTH{w_sub}};

   adder #(
      .WIDTH (WIDTH)
   ) u_adder (
      .a     (w_a),
      .b     (w_b_eff),
      .cin   (w_sub),
      .sum   (w_sum),
      .cout  (w_cout)
   );

   assign w_ovf = (w_a[WIDTH-1] == w_b_eff[WIDTH-1]) & (w_sum[WIDTH-1] != w_a[WIDTH-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_resp  <= '0;
      end else if (w_advance) begin
         r_valid     <= 1'b1;
         r_resp.sum  <= ADDER_ARB_MAX_WIDTH'(w_sum);
         r_resp.cout <= w_cout;
         r_resp.ovf  <= w_ovf;
         r_resp.id   <= ADDER_ARB_MAX_IDW'(w_id);
      end else if (resp_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign resp_valid = r_valid;
   assign resp_sum   = r_resp.sum[WIDTH-1:0];
   assign resp_cout  = r_resp.cout;
   assign resp_ovf   = r_resp.ovf;
   assign resp_id    = r_resp.id[IDW-1:0];

   // The padding bits of the shared response layout are never presented.
   logic [$bits(adder_resp_t)-1:0] w_unused_resp;
   assign w_unused_resp = r_resp;

endmodule

`default_nettype wire

// File: tb/tb_adder_arbiter.sv
// ============================================================================
//  Module      : tb_adder_arbiter
//  Description : Self-checking bench for adder_arbiter (WIDTH=32, NREQ=4).
//                A behavioural model (arithmetic on wide signed integers plus
//                a modular round-robin pointer) predicts req_ready and the
//                output register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_arbiter;

   localparam int W  = 32;
   localparam int N  = 4;
   localparam int IW = 2;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*W-1:0]  req_a;
   logic [N*W-1:0]  req_b;
   logic [N-1:0]    req_sub;
   logic            resp_valid;
   logic            resp_ready;
   logic [W-1:0]    resp_sum;
   logic            resp_cout;
   logic            resp_ovf;
   logic [IW-1:0]   resp_id;

   adder_arbiter #(.WIDTH(W), .NREQ(N), .IDW(IW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_sub    (req_sub),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_sum   (resp_sum),
      .resp_cout  (resp_cout),
      .resp_ovf   (resp_ovf),
      .resp_id    (resp_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Per-requester operands held by the bench.
   logic [W-1:0] op_a   [N];
   logic [W-1:0] op_b   [N];
   logic         op_sub [N];

   // Reference model state.
   int           m_ptr;
   logic         m_valid;
   logic [W-1:0] m_sum;
   logic         m_cout;
   logic         m_ovf;
   int           m_id;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Expected arithmetic from integer semantics. No adder structure is used.
   function automatic void calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                output logic [W-1:0] s, output logic co, output logic ov);
      longint sa, sb, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sub) begin
         s  = a - b;
         co = (a >= b);
         r  = sa - sb;
      end else begin
         {co, s} = {1'b0, a} + {1'b0, b};
         r = sa + sb;
      end
      ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
   endfunction

   function automatic int onehot_idx(input logic [N-1:0] v);
      if ($countones(v) != 1) return -1;
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic int model_winner();
      for (int k = 0; k < N; k++) begin
         if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_valid = 1'b0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_id = 0;
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_a[i*W +: W] = op_a[i];
         req_b[i*W +: W] = op_b[i];
         req_sub[i]      = op_sub[i];
      end
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h7FFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // One clock cycle. Call just after a falling edge with inputs set.
   // Checks req_ready before the edge and the output register after it.
   task automatic step(output logic [N-1:0] dut_rdy, output int exp_g);
      logic [N-1:0] er;
      int w;
      drive();
      #1;
      w  = model_winner();
      er = '0;
      if (rst_n && (!m_valid || resp_ready) && w >= 0) er[w] = 1'b1;
      exp_g   = (er != '0) ? w : -1;
      dut_rdy = req_ready;
      chk("req_ready", 64'(req_ready), 64'(er));
      @(posedge clk);
      if (er != '0) begin
         calc(op_a[w], op_b[w], op_sub[w], m_sum, m_cout, m_ovf);
         m_valid = 1'b1;
         m_id    = w;
         m_ptr   = (w + 1) % N;
      end else if (m_valid && resp_ready) begin
         m_valid = 1'b0;
      end
      #1;
      chk("resp_valid", 64'(resp_valid), 64'(m_valid));
      chk("resp_sum",   64'(resp_sum),   64'(m_sum));
      chk("resp_cout",  64'(resp_cout),  64'(m_cout));
      chk("resp_ovf",   64'(resp_ovf),   64'(m_ovf));
      chk("resp_id",    64'(resp_id),    64'(m_id));
      @(negedge clk);
   endtask

   initial begin
      logic [N-1:0] rdy;
      int           g;
      int           rr_exp [5];
      logic [W-1:0] es;
      logic         ec, eo;
      logic [N-1:0] pend;
      int           age [N];

      rr_exp = '{0, 1, 2, 3, 0};
      tbl[0] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
      tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      tbl[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
      tbl[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      tbl[4] = '{32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
      tbl[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

      // ---------------- reset with random inputs ----------------
      rst_n = 1'b0;
      model_reset();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         req_valid  = N'($urandom);
         resp_ready = 1'($urandom);
         for (int i = 0; i < N; i++) begin
            op_a[i] = $urandom; op_b[i] = $urandom; op_sub[i] = 1'($urandom);
         end
         drive();
         #3;
         chk("rst_req_ready",  64'(req_ready),  64'(0));
         chk("rst_resp_valid", 64'(resp_valid), 64'(0));
         chk("rst_resp_sum",   64'(resp_sum),   64'(0));
         chk("rst_resp_flags", 64'({resp_cout, resp_ovf}), 64'(0));
         chk("rst_resp_id",    64'(resp_id),    64'(0));
      end
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = '0; resp_ready = 1'b1;
      step(rdy, g);

      op_a[2] = 32'd5; op_b[2] = 32'd7; op_sub[2] = 1'b0;
      req_valid = 4'b0100;
      step(rdy, g);
      chk("r2_grant", 64'(rdy), 64'(4'b0100));
      chk("r2_sum",   64'(resp_sum), 64'(12));
      chk("r2_flags", 64'({resp_cout, resp_ovf}), 64'(0));
      chk("r2_id",    64'(resp_id), 64'(2));

      // ---------------- flag table via requester 0 ----------------
      for (int i = 0; i < 6; i++) begin
         op_a[0] = tbl[i].a; op_b[0] = tbl[i].b; op_sub[0] = tbl[i].sub;
         req_valid = 4'b0001;
         step(rdy, g);
         chk("tbl_sum",  64'(resp_sum),  64'(tbl[i].sum));
         chk("tbl_cout", 64'(resp_cout), 64'(tbl[i].cout));
         chk("tbl_ovf",  64'(resp_ovf),  64'(tbl[i].ovf));
         chk("tbl_id",   64'(resp_id),   64'(0));
      end

      // ---------------- round robin ----------------
      req_valid = 4'b1000;  // ptr lands on 0
      step(rdy, g);
      for (int i = 0; i < N; i++) begin
         op_a[i] = $urandom; op_b[i] = $urandom; op_sub[i] = 1'($urandom);
      end
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         step(rdy, g);
         chk("rr_grant", 64'(onehot_idx(rdy)), 64'(rr_exp[k]));
         chk("rr_id",    64'(resp_id),         64'(rr_exp[k]));
         chk("rr_valid", 64'(resp_valid),      64'(1));
      end

      // ---------------- backpressure ----------------
      op_a[1] = 32'h1234_0000; op_b[1] = 32'h0000_5678; op_sub[1] = 1'b0;
      op_a[3] = 32'h0000_0010; op_b[3] = 32'h0000_0020; op_sub[3] = 1'b1;
      req_valid = 4'b1010;
      step(rdy, g);
      chk("bp_fill", 64'(rdy), 64'(4'b0010));
      resp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step(rdy, g);
         chk("bp_ready", 64'(rdy),      64'(0));
         chk("bp_sum",   64'(resp_sum), 64'(32'h1234_5678));
         chk("bp_id",    64'(resp_id),  64'(1));
      end
      resp_ready = 1'b1;
      step(rdy, g);
      calc(op_a[3], op_b[3], op_sub[3], es, ec, eo);
      chk("bp_grant", 64'(rdy),        64'(4'b1000));
      chk("bp_valid", 64'(resp_valid), 64'(1));
      chk("bp_new",   64'(resp_sum),   64'(32'hFFFF_FFF0));
      chk("bp_newid", 64'(resp_id),    64'(3));

      // ---------------- sparse requests / wrap ----------------
      req_valid = 4'b1000;
      step(rdy, g);
      chk("sp_r3", 64'(rdy), 64'(4'b1000));
      req_valid = 4'b0010;
      step(rdy, g);
      chk("sp_r1", 64'(rdy), 64'(4'b0010));
      req_valid = 4'b1111;
      step(rdy, g);
      chk("sp_ptr2", 64'(rdy), 64'(4'b0100));

      // ---------------- async reset while FULL ----------------
      req_valid = 4'b0001;
      step(rdy, g);
      req_valid = '0; resp_ready = 1'b0;
      step(rdy, g);
      chk("ar_full", 64'(resp_valid), 64'(1));
      #2;
      rst_n = 1'b0;
      req_valid = 4'b1111;
      #1;
      model_reset();
      chk("ar_valid", 64'(resp_valid), 64'(0));
      chk("ar_sum",   64'(resp_sum),   64'(0));
      chk("ar_id",    64'(resp_id),    64'(0));
      chk("ar_ready", 64'(req_ready),  64'(0));
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = '0;
      step(rdy, g);
      chk("ar_stale", 64'(resp_valid), 64'(0));
      req_valid = 4'b1111; resp_ready = 1'b1;
      step(rdy, g);
      chk("ar_ptr0", 64'(rdy), 64'(4'b0001));

      // ---------------- randomized traffic ----------------
      req_valid = '0;
      step(rdy, g);
      pend = '0;
      for (int i = 0; i < N; i++) age[i] = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
               pend[i] = 1'b1; op_a[i] = pick(); op_b[i] = pick(); op_sub[i] = 1'($urandom);
            end
         end
         req_valid  = pend;
         resp_ready = ($urandom_range(0, 3) != 0);
         step(rdy, g);
         if (g >= 0) begin
            chk("fair", 64'((age[g] < N) ? 1 : 0), 64'(1));
            age[g]  = 0;
            pend[g] = 1'b0;
            for (int i = 0; i < N; i++) if (pend[i]) age[i]++;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
